// File: rtl/pc_core_rd_burst_scheduler.sv
// pc_core_rd_burst_scheduler
//   Shares one AXI4 read-address channel between NUM_REQ job requesters. One job is granted
//   at a time (round-robin) and split into bursts limited by MAX_BURST and 4 KB page ends.
//   An outstanding-burst counter gates issue so no more than MAX_OUTSTANDING are in flight.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         per-requester job handshake (ready is one-hot or zero)
//   req_addr/req_beats          packed per-requester job start address / length in beats
//   ar_valid/ar_ready           burst address handshake
//   ar_addr/ar_len/ar_id        burst start address, AXI len (beats-1), owning requester
//   burst_done                  one issued burst fully returned
//   job_done/job_done_id        pulse after the last burst of a job has issued
//   outstanding                 bursts issued but not yet returned
//   err_underflow               sticky: burst_done arrived with nothing outstanding
module pc_core_rd_burst_scheduler #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned LEN_WIDTH       = 32,
    parameter int unsigned BEAT_BYTES      = 64,
    parameter int unsigned MAX_BURST       = 64,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]           req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]            req_beats,
    output logic                                    ar_valid,
    input  logic                                    ar_ready,
    output logic [ADDR_WIDTH-1:0]                   ar_addr,
    output logic [7:0]                              ar_len,
    output logic [$clog2(NUM_REQ)-1:0]              ar_id,
    input  logic                                    burst_done,
    output logic                                    job_done,
    output logic [$clog2(NUM_REQ)-1:0]              job_done_id,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
    output logic                                    err_underflow
);

    localparam int unsigned ID_W       = $clog2(NUM_REQ);
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned BLEN_W     = 9;
    localparam int unsigned PAGE_W     = 13;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [BLEN_W-1:0]       blen_q, blen_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    job_done_q, job_done_d;
    logic [ID_W-1:0]         job_done_id_q, job_done_id_d;
    logic [OUT_W-1:0]        out_q, out_d;
    logic                    err_q, err_d;

    logic                    grant_found;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W-1:0]         scan_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [LEN_WIDTH-1:0]    sel_beats;
    logic [PAGE_W-1:0]       page_beats;
    logic [BLEN_W-1:0]       blen_calc;
    logic                    hs;
    logic                    credit_ok;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
        req_ready = '0;
        if (state_q == S_IDLE && !rst && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_addr  = '0;
        sel_beats = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_beats = req_beats[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Burst length: min(remaining, MAX_BURST, beats left before the 4 KB boundary).
    always_comb begin
        page_beats = (PAGE_W'(4096) - PAGE_W'(addr_q[11:0])) >> BEAT_SHIFT;
        blen_calc  = BLEN_W'(MAX_BURST);
        if (page_beats < PAGE_W'(blen_calc)) begin
            blen_calc = BLEN_W'(page_beats);
        end
        if (rem_q < LEN_WIDTH'(blen_calc)) begin
            blen_calc = BLEN_W'(rem_q);
        end
    end

    // Credit counter; a simultaneous issue and return cancel out.
    always_comb begin
        hs    = ar_valid_q && ar_ready;
        out_d = out_q;
        err_d = err_q;
        if (hs && !burst_done) begin
            out_d = out_q + OUT_W'(1);
        end else if (!hs && burst_done) begin
            if (out_q == '0) begin
                err_d = 1'b1;
            end else begin
                out_d = out_q - OUT_W'(1);
            end
        end
        // Judged on next-cycle occupancy so a raised ar_valid always has a credit behind it.
        credit_ok = out_d < OUT_W'(MAX_OUTSTANDING);
    end

    // Job FSM next state and registered outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        blen_d        = blen_q;
        ar_valid_d    = ar_valid_q;
        job_done_d    = (state_q == S_DONE);
        job_done_id_d = (state_q == S_DONE) ? id_q : job_done_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    id_d    = grant_id;
                    ptr_d   = grant_id;
                    addr_d  = sel_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
                    rem_d   = sel_beats;
                    state_d = (sel_beats == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                blen_d     = blen_calc;
                ar_valid_d = credit_ok;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (hs) begin
                    addr_d     = addr_q + (ADDR_WIDTH'(blen_q) << BEAT_SHIFT);
                    rem_d      = rem_q - LEN_WIDTH'(blen_q);
                    ar_valid_d = 1'b0;
                    state_d    = (rem_q == LEN_WIDTH'(blen_q)) ? S_DONE : S_CALC;
                end else if (!ar_valid_q) begin
                    ar_valid_d = credit_ok;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= ID_W'(NUM_REQ - 1);
            id_q          <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            blen_q        <= '0;
            ar_valid_q    <= 1'b0;
            job_done_q    <= 1'b0;
            job_done_id_q <= '0;
            out_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            blen_q        <= blen_d;
            ar_valid_q    <= ar_valid_d;
            job_done_q    <= job_done_d;
            job_done_id_q <= job_done_id_d;
            out_q         <= out_d;
            err_q         <= err_d;
        end
    end

    assign ar_valid      = ar_valid_q;
    assign ar_addr       = addr_q;
    assign ar_len        = 8'(blen_q - BLEN_W'(1));
    assign ar_id         = id_q;
    assign job_done      = job_done_q;
    assign job_done_id   = job_done_id_q;
    assign outstanding   = out_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_pc_core_rd_burst_scheduler.sv
// tb_pc_core_rd_burst_scheduler
//   Scoreboard bench: stimulus pushes expected AR bursts, job completions and point-in-time
//   status probes into queues; a negedge monitor pops and compares them.
//   DUT runs with MAX_OUTSTANDING = 2 so credit stalls are easy to provoke.
module tb_pc_core_rd_burst_scheduler;

    localparam int NR = 4;
    localparam int AW = 64;
    localparam int LW = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*LW-1:0] req_beats = '0;
    logic             ar_valid;
    logic             ar_ready = 1'b0;
    logic [AW-1:0]    ar_addr;
    logic [7:0]       ar_len;
    logic [1:0]       ar_id;
    logic             burst_done;
    logic             bd_auto = 1'b0;
    logic             bd_raw = 1'b0;
    logic             job_done;
    logic [1:0]       job_done_id;
    logic [1:0]       outstanding;
    logic             err_underflow;

    assign burst_done = bd_auto | bd_raw;

    always #5 clk = ~clk;

    pc_core_rd_burst_scheduler #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .BEAT_BYTES(64), .MAX_BURST(64), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_beats(req_beats),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
        .burst_done(burst_done),
        .job_done(job_done), .job_done_id(job_done_id),
        .outstanding(outstanding), .err_underflow(err_underflow)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  id;
    } ar_exp_t;

    typedef struct packed {
        logic [3:0]  kind;
        logic [63:0] exp;
    } probe_t;

    ar_exp_t    exp_ar[$];
    logic [1:0] exp_job[$];
    probe_t     probes[$];

    int checks   = 0;
    int errors   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int man_cnt  = 0;
    int tmo      = 0;
    int hs_base  = 0;
    bit auto_done = 1'b0;
    bit finished  = 1'b0;

    function automatic string kname(input logic [3:0] k);
        case (k)
            4'd0: return "outstanding";
            4'd1: return "err_underflow";
            4'd2: return "ar_valid";
            4'd3: return "req_ready";
            4'd4: return "job_done";
            4'd5: return "ar_addr";
            4'd6: return "ar_len";
            default: return "handshakes";
        endcase
    endfunction

    // Monitor / scoreboard
    initial begin
        ar_exp_t     e;
        probe_t      p;
        logic [1:0]  j;
        logic [63:0] act;
        int          cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ar_valid && ar_ready && !rst) begin
                hs_cnt++;
                checks++;
                if (exp_ar.size() == 0) begin
                    errors++;
                    $display("FAIL ar_unexpected: got addr=%h len=%0d id=%0d, required no burst",
                             ar_addr, ar_len, ar_id);
                end else begin
                    e = exp_ar.pop_front();
                    if (ar_addr != e.addr || ar_len != e.len || ar_id != e.id) begin
                        errors++;
                        $display("FAIL ar_burst: got addr=%h len=%0d id=%0d, required addr=%h len=%0d id=%0d",
                                 ar_addr, ar_len, ar_id, e.addr, e.len, e.id);
                    end
                end
            end
            if (job_done && !rst) begin
                checks++;
                if (exp_job.size() == 0) begin
                    errors++;
                    $display("FAIL job_unexpected: got job_done id=%0d, required none", job_done_id);
                end else begin
                    j = exp_job.pop_front();
                    if (job_done_id != j) begin
                        errors++;
                        $display("FAIL job_done_id: got %0d, required %0d", job_done_id, j);
                    end
                end
            end
            while (probes.size() != 0) begin
                p = probes.pop_front();
                case (p.kind)
                    4'd0: act = 64'(outstanding);
                    4'd1: act = 64'(err_underflow);
                    4'd2: act = 64'(ar_valid);
                    4'd3: act = 64'(req_ready);
                    4'd4: act = 64'(job_done);
                    4'd5: act = ar_addr;
                    4'd6: act = 64'(ar_len);
                    default: act = 64'(hs_cnt);
                endcase
                checks++;
                if (act != p.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h, required %0h", kname(p.kind), act, p.exp);
                end
            end
            if (finished || cyc > 40000) begin
                if (!finished) begin
                    checks++;
                    errors++;
                    $display("FAIL watchdog: got %0d cycles, required finish before 40000", cyc);
                end
                checks++;
                if (tmo != 0) begin
                    errors++;
                    $display("FAIL wait_timeouts: got %0d, required 0", tmo);
                end
                checks++;
                if (exp_ar.size() != 0 || exp_job.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: got %0d bursts %0d jobs pending, required 0 0",
                             exp_ar.size(), exp_job.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    // Memory-side responder: returns each issued burst one cycle later when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                done_cnt = hs_cnt;
                bd_auto  = 1'b0;
            end else if (auto_done && (done_cnt + man_cnt < hs_cnt)) begin
                bd_auto = 1'b1;
                done_cnt++;
            end else begin
                bd_auto = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int k, input logic [63:0] v);
        probes.push_back({4'(k), v});
    endtask

    task automatic exp_burst(input logic [63:0] a, input int len, input int id);
        exp_ar.push_back({a, 8'(len), 2'(id)});
    endtask

    task automatic submit(input int i, input logic [63:0] a, input logic [31:0] b);
        int n;
        req_addr[i*AW +: AW]  = a;
        req_beats[i*LW +: LW] = b;
        req_valid[i] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[i] && n < 500) begin
            tick();
            n++;
        end
        if (!req_ready[i]) tmo++;
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_ar.size() != 0 || exp_job.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) tmo++;
        repeat (4) tick();
    endtask

    task automatic wait_ar_valid();
        int n;
        n = 0;
        while (!ar_valid && n < 200) begin
            tick();
            n++;
        end
        if (!ar_valid) tmo++;
    endtask

    // Stimulus
    initial begin
        int acc;
        repeat (3) tick();
        rst = 1'b0;
        probe(0, 0); probe(1, 0); probe(2, 0); probe(3, 0); probe(4, 0);
        tick();

        // T1: 130 beats from 0 -> 64, 64, 2 beats
        ar_ready  = 1'b1;
        auto_done = 1'b1;
        exp_burst(64'h0,    63, 0);
        exp_burst(64'h1000, 63, 0);
        exp_burst(64'h2000, 1,  0);
        exp_job.push_back(2'd0);
        submit(0, 64'h0, 32'd130);
        wait_drain();

        // T2: 4 KB page split
        exp_burst(64'h0FC0, 0, 2);
        exp_burst(64'h1000, 2, 2);
        exp_job.push_back(2'd2);
        submit(2, 64'h0FC0, 32'd4);
        wait_drain();

        // T3: round-robin from reset, all requesters held
        rst = 1'b1;
        man_cnt = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = 64'(i) * 64'h100;
            req_beats[i*LW +: LW] = 32'd1;
        end
        foreach (exp_ar[k]) exp_ar.delete(k);
        exp_burst(64'h000, 0, 0); exp_job.push_back(2'd0);
        exp_burst(64'h100, 0, 1); exp_job.push_back(2'd1);
        exp_burst(64'h200, 0, 2); exp_job.push_back(2'd2);
        exp_burst(64'h300, 0, 3); exp_job.push_back(2'd3);
        exp_burst(64'h000, 0, 0); exp_job.push_back(2'd0);
        req_valid = 4'hF;
        #1;
        probe(3, 64'h1);
        acc = 0;
        for (int n = 0; n < 500; n++) begin
            if (req_ready != '0) begin
                acc++;
                if (acc == 5) break;
            end
            tick();
        end
        if (acc != 5) tmo++;
        tick();
        req_valid = '0;
        wait_drain();

        // T4: credit stall at MAX_OUTSTANDING = 2, five bursts
        probe(0, 0);
        auto_done = 1'b0;
        hs_base = hs_cnt;
        for (int b = 0; b < 5; b++) exp_burst(64'h10000 + 64'(b) * 64'h1000, 63, 3);
        exp_job.push_back(2'd3);
        submit(3, 64'h10000, 32'd320);
        repeat (20) tick();
        probe(0, 2); probe(2, 0); probe(7, 64'(hs_base + 2));
        tick();
        bd_raw = 1'b1;
        man_cnt++;
        tick();
        bd_raw = 1'b0;
        repeat (10) tick();
        probe(0, 2); probe(2, 0); probe(7, 64'(hs_base + 3));
        tick();
        auto_done = 1'b1;
        wait_drain();

        // T5: zero-length job, then underflow
        probe(0, 0);
        auto_done = 1'b0;
        exp_job.push_back(2'd1);
        submit(1, 64'h7000, 32'd0);
        probe(4, 0); probe(2, 0);
        tick();
        probe(4, 1); probe(2, 0);
        tick();
        bd_raw = 1'b1;
        tick();
        bd_raw = 1'b0;
        probe(1, 1); probe(0, 0);
        repeat (5) tick();
        probe(1, 1);
        tick();

        // T6: backpressure, simultaneous issue/return, reset mid-job
        rst = 1'b1;
        man_cnt = 0;
        tick();
        rst = 1'b0;
        probe(1, 0); probe(0, 0);
        tick();
        ar_ready = 1'b1;
        exp_burst(64'h5000, 0, 0);
        exp_job.push_back(2'd0);
        submit(0, 64'h5000, 32'd1);
        wait_drain();
        probe(0, 1);
        ar_ready = 1'b0;
        exp_burst(64'h0000_3000_0000_0040, 2, 2);
        exp_job.push_back(2'd2);
        submit(2, 64'h0000_3000_0000_0040, 32'd3);
        wait_ar_valid();
        for (int c = 0; c < 10; c++) begin
            probe(2, 1); probe(5, 64'h0000_3000_0000_0040); probe(6, 2);
            tick();
        end
        ar_ready = 1'b1;
        bd_raw   = 1'b1;
        tick();
        ar_ready = 1'b0;
        bd_raw   = 1'b0;
        probe(0, 1);
        wait_drain();
        submit(1, 64'h8000, 32'd200);
        wait_ar_valid();
        probe(2, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        probe(2, 0); probe(0, 0); probe(4, 0); probe(1, 0); probe(3, 0);
        repeat (3) tick();
        probe(2, 0);
        repeat (2) tick();
        finished = 1'b1;
    end

endmodule
